// File: rtl/step_pulse_gen_pkg.sv
// Shared types and constants for the step pulse generator.
// Latency: n/a (definitions only).
// Backpressure: none; the generator ignores commands while a train is running.
package step_pulse_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam int WAVE_STEP = 0;
  localparam int WAVE_DIR  = 1;
  localparam int WAVE_EN   = 2;

  localparam int DEF_CNT_W = 8;
  localparam int DEF_DIV_W = 16;

endpackage

// File: rtl/step_pulse_gen_pulse_timer.sv
// Loadable down-counter timing one step phase; tc marks the phase's last cycle.
// Latency: a value loaded on an edge gives tc after load_val cycles (load_val >= 1).
// Backpressure: none; load always wins over counting.
module step_pulse_gen_pulse_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  // Count down the remaining cycles of the current phase, parking at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // A count of one means this is the final cycle of the phase.
  assign tc = (cnt == {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/step_pulse_gen.sv
// Emits a train of pulse_num step pulses (H high / H low) on wave, abortable by stop_in.
// Latency: step rises one cycle after an accepted start; done one cycle after the train ends.
// Backpressure: start is ignored while busy; stop_in lets the current high phase finish.
module step_pulse_gen
  import step_pulse_gen_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] pulse_num,
  input  logic [DIV_W-1:0] half_period,
  input  logic             dir,
  input  logic             stop_in,
  output logic [2:0]       wave,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] remaining,
  output logic             limit_hit
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] rem_q;
  logic [DIV_W-1:0] h_q;
  logic [DIV_W-1:0] h_in;
  logic             dir_q;
  logic             done_q;
  logic             limit_q;
  logic             stop_pend;
  logic             tc;
  logic             accept;
  logic             stop_end;
  logic             tmr_load;
  logic [DIV_W-1:0] tmr_val;

  // A zero half-period is run as one cycle so the train always advances.
  assign h_in     = (half_period == '0) ? {{(DIV_W-1){1'b0}}, 1'b1} : half_period;
  assign accept   = (state == IDLE) && start;
  // Abort paths: a stop seen during HIGH waits for the high phase to end; LOW aborts at once.
  assign stop_end = ((state == HIGH) && tc && (stop_in || stop_pend)) ||
                    ((state == LOW) && stop_in);

  // While idle the timer tracks the incoming half-period so the first phase is ready on accept.
  assign tmr_load = (state == IDLE) || tc;
  assign tmr_val  = (state == IDLE) ? h_in : h_q;

  step_pulse_gen_pulse_timer #(.W(DIV_W)) u_timer (
    .clk      (sysclk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tc)
  );

  // State register.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state selection between idle, high and low phases.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start && !stop_in && (pulse_num != '0)) state_nxt = HIGH;
      end
      HIGH: begin
        if (tc) state_nxt = (stop_in || stop_pend) ? IDLE : LOW;
      end
      LOW: begin
        if (stop_in) begin
          state_nxt = IDLE;
        end else if (tc) begin
          state_nxt = (rem_q != '0) ? HIGH : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; direction stays on the bus even when disabled.
  always_comb begin
    wave            = 3'b000;
    wave[WAVE_STEP] = (state == HIGH);
    wave[WAVE_DIR]  = dir_q;
    wave[WAVE_EN]   = (state != IDLE);
    busy            = (state != IDLE);
    done            = done_q;
    remaining       = rem_q;
    limit_hit       = limit_q;
  end

  // Command latching, pulse accounting and end-of-train status.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      rem_q     <= '0;
      h_q       <= '0;
      dir_q     <= 1'b0;
      done_q    <= 1'b0;
      limit_q   <= 1'b0;
      stop_pend <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (state == IDLE) begin
        stop_pend <= 1'b0;
      end else if ((state == HIGH) && stop_in) begin
        stop_pend <= 1'b1;
      end

      if (accept) begin
        rem_q   <= pulse_num;
        h_q     <= h_in;
        dir_q   <= dir;
        limit_q <= stop_in;
        if (stop_in || (pulse_num == '0)) done_q <= 1'b1;
      end else begin
        if ((state != IDLE) && (state_nxt == IDLE)) begin
          done_q <= 1'b1;
          if (stop_end) limit_q <= 1'b1;
        end
        // A pulse counts as sent when its high phase ends.
        if ((state == HIGH) && tc && (rem_q != '0)) rem_q <= rem_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_step_pulse_gen.sv
// Directed bench for step_pulse_gen with a cycle-offset reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_step_pulse_gen;

  localparam int CNT_W = 8;
  localparam int DIV_W = 16;

  logic             sysclk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] pulse_num = '0;
  logic [DIV_W-1:0] half_period = '0;
  logic             dir = 1'b0;
  logic             stop_in = 1'b0;
  logic [2:0]       wave;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] remaining;
  logic             limit_hit;

  int checks = 0;
  int errors = 0;

  always #5 sysclk = ~sysclk;

  step_pulse_gen #(.CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
    .sysclk      (sysclk),
    .reset       (reset),
    .start       (start),
    .pulse_num   (pulse_num),
    .half_period (half_period),
    .dir         (dir),
    .stop_in     (stop_in),
    .wave        (wave),
    .busy        (busy),
    .done        (done),
    .remaining   (remaining),
    .limit_hit   (limit_hit)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a train is described by N, H, direction and its length L in cycles.
  // m_k is the offset of the current output cycle from the first high cycle.
  int unsigned m_n = 0, m_h = 1, m_k = 0, m_l = 0, nl;
  bit m_act = 0, m_dir = 0, m_done = 0, m_lim = 0, m_stopped = 0, m_valid = 0;

  always @(posedge sysclk) begin
    if (reset) begin
      m_n = 0; m_h = 1; m_k = 0; m_l = 0;
      m_act = 0; m_dir = 0; m_done = 0; m_lim = 0; m_stopped = 0;
      m_valid = 1;
    end else begin
      m_done = 0;
      if (m_act) begin
        if (stop_in) begin
          if ((m_k % (2 * m_h)) < m_h) nl = (m_k / (2 * m_h)) * 2 * m_h + m_h;
          else                         nl = m_k + 1;
          if (nl < m_l) m_l = nl;
          m_stopped = 1;
        end
        m_k++;
        if (m_k == m_l) begin
          m_act  = 0;
          m_done = 1;
          m_lim  = m_stopped;
        end
      end else if (start) begin
        m_n   = pulse_num;
        m_h   = (half_period == 0) ? 1 : half_period;
        m_dir = dir;
        m_k   = 0;
        m_lim = 0;
        m_stopped = 0;
        if (stop_in) begin
          m_lim  = 1;
          m_done = 1;
        end else if (m_n == 0) begin
          m_done = 1;
        end else begin
          m_act = 1;
          m_l   = 2 * m_h * m_n;
        end
      end
    end
  end

  // Compare every cycle on the falling edge once the model has seen reset.
  always @(negedge sysclk) begin
    bit exp_step;
    int exp_rem;
    if (m_valid) begin
      exp_step = m_act && ((m_k % (2 * m_h)) < m_h);
      exp_rem  = int'(m_n - (m_k + m_h) / (2 * m_h));
      chk("model wave", int'(wave), int'({m_act, m_dir, exp_step}));
      chk("model busy", int'(busy), int'(m_act));
      chk("model done", int'(done), int'(m_done));
      chk("model remaining", int'(remaining), exp_rem);
      chk("model limit_hit", int'(limit_hit), int'(m_lim));
    end
  end

  task automatic issue(input int n, input int h, input bit d);
    pulse_num   = n[CNT_W-1:0];
    half_period = h[DIV_W-1:0];
    dir         = d;
    start       = 1'b1;
    @(negedge sysclk);
    start       = 1'b0;
  endtask

  // Counts busy cycles from the current one; ends on the first idle cycle.
  task automatic count_busy(input int lim, output int n);
    n = 0;
    while (busy && n < lim) begin
      n++;
      @(negedge sysclk);
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL busy timeout: still busy after %0d cycles", lim);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge sysclk);
    chk("reset wave", int'(wave), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset remaining", int'(remaining), 0);
    chk("reset limit_hit", int'(limit_hit), 0);
    reset = 1'b0;
    @(negedge sysclk);

    // Full train N=4 H=3 dir=1.
    issue(4, 3, 1'b1);
    chk("t1 first step latency", int'(wave), 7);
    repeat (3) @(negedge sysclk);
    chk("t1 first low step", int'(wave), 6);
    chk("t1 remaining after first fall", int'(remaining), 3);
    count_busy(60, n);
    chk("t1 busy cycles after k3", n, 21);
    chk("t1 done at end", int'(done), 1);
    chk("t1 remaining end", int'(remaining), 0);
    chk("t1 idle wave keeps dir", int'(wave), 2);
    repeat (2) @(negedge sysclk);

    // Zero-length command.
    issue(0, 5, 1'b0);
    chk("t2 done", int'(done), 1);
    chk("t2 busy", int'(busy), 0);
    chk("t2 limit_hit", int'(limit_hit), 0);
    chk("t2 wave", int'(wave), 0);
    repeat (2) @(negedge sysclk);

    // Stop already asserted at start.
    stop_in = 1'b1;
    issue(5, 2, 1'b1);
    stop_in = 1'b0;
    chk("t3 done", int'(done), 1);
    chk("t3 limit_hit", int'(limit_hit), 1);
    chk("t3 busy", int'(busy), 0);
    chk("t3 remaining", int'(remaining), 5);
    repeat (2) @(negedge sysclk);

    // Stop in the 2nd cycle of the 3rd high phase, N=10 H=2.
    issue(10, 2, 1'b1);
    repeat (9) @(negedge sysclk);
    chk("t4 in third high", int'(wave), 7);
    stop_in = 1'b1;
    @(negedge sysclk);
    stop_in = 1'b0;
    chk("t4 done", int'(done), 1);
    chk("t4 limit_hit", int'(limit_hit), 1);
    chk("t4 remaining", int'(remaining), 7);
    chk("t4 wave", int'(wave), 2);
    repeat (2) @(negedge sysclk);
    chk("t4 limit_hit held", int'(limit_hit), 1);

    // Start while busy is ignored; a later start runs normally.
    issue(3, 2, 1'b0);
    chk("t5 limit_hit cleared", int'(limit_hit), 0);
    @(negedge sysclk);
    issue(9, 1, 1'b1);
    count_busy(60, n);
    chk("t5 ignored restart busy", n, 10);
    chk("t5 remaining", int'(remaining), 0);
    chk("t5 dir unchanged", int'(wave), 0);
    @(negedge sysclk);
    issue(9, 1, 1'b1);
    count_busy(60, n);
    chk("t5 second train busy", n, 18);
    chk("t5 second done", int'(done), 1);

    // Reset in the middle of a high phase.
    issue(5, 3, 1'b1);
    @(negedge sysclk);
    reset = 1'b1;
    @(negedge sysclk);
    chk("t6 wave", int'(wave), 0);
    chk("t6 busy", int'(busy), 0);
    chk("t6 remaining", int'(remaining), 0);
    chk("t6 done", int'(done), 0);
    reset = 1'b0;
    @(negedge sysclk);
    chk("t6 no done after", int'(done), 0);

    // Half-period zero acts as one.
    issue(2, 0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("t7 step pattern", int'(wave[0]), (i % 2 == 0) ? 1 : 0);
      @(negedge sysclk);
    end
    chk("t7 done", int'(done), 1);
    chk("t7 busy", int'(busy), 0);
    repeat (2) @(negedge sysclk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
